// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit positions, glyph table and
// digit type, used by the display driver and by the capture block.
package seven_segment_pkg;

    // Bit positions on the cathode bus (active low on the pins)
    typedef enum int {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } seg_idx_e;

    typedef logic [3:0] digit_t;   // one hex digit
    typedef logic [6:0] glyph_t;   // active-high gfedcba pattern

    localparam int NUM_GLYPHS = 16;

    // Index i holds the active-high gfedcba pattern that shows hex value i
    localparam glyph_t GLYPH_TABLE [NUM_GLYPHS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup: active-high segment pattern to hex nibble,
// with a flag saying whether the pattern is one of the sixteen glyphs.
module seg_decode
    import seven_segment_pkg::*;
(
    input  glyph_t i_pattern,
    output digit_t o_nibble,
    output logic   o_legal
);

    // Search the glyph table for an exact pattern match
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_nibble = '0;
        o_legal  = 1'b0;
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (i_pattern == GLYPH_TABLE[i]) begin
                o_nibble = digit_t'(i);
                o_legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers the digits shown on a multiplexed seven-segment display by
// watching its anode/cathode lines, and publishes a whole frame at once.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int NUM_SEGMENTS = 8,
    parameter int STABLE_CYC   = 16,
    parameter int CLK_PER      = 10,
    parameter int REFR_RATE    = 1000
) (
    input  logic                      clk,
    input  logic                      CPU_RESETN,
    input  logic [NUM_SEGMENTS-1:0]   anode,
    input  logic [7:0]                cathode,
    output digit_t [NUM_SEGMENTS-1:0] encoded,
    output logic [NUM_SEGMENTS-1:0]   decimal,
    output logic                      frame_valid,
    output logic                      glyph_err,
    output logic                      multi_err,
    output logic                      stale
);

    localparam int              CNT_W       = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYC - 1);
    // Capture fires on the increment that takes the counter to CNT_MAX
    localparam logic [CNT_W-1:0] CNT_HIT    = CNT_W'(STABLE_CYC - 2);
    localparam int              TIMEOUT_CYC = 4 * (1_000_000_000 / (CLK_PER * REFR_RATE));
    localparam int              TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT_CYC);
    localparam int              IDX_W       = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

    (* ASYNC_REG = "TRUE" *) logic [NUM_SEGMENTS-1:0] r_anode_s1;
    (* ASYNC_REG = "TRUE" *) logic [NUM_SEGMENTS-1:0] r_anode_s2;
    (* ASYNC_REG = "TRUE" *) logic [7:0]              r_cath_s1;
    (* ASYNC_REG = "TRUE" *) logic [7:0]              r_cath_s2;
    logic [NUM_SEGMENTS-1:0]   r_anode_prev;
    logic [7:0]                r_cath_prev;
    logic [CNT_W-1:0]          r_stable_cnt;
    logic [TO_W-1:0]           r_to_cnt;
    logic [NUM_SEGMENTS-1:0]   r_seen;
    digit_t [NUM_SEGMENTS-1:0] r_shadow_enc;
    logic [NUM_SEGMENTS-1:0]   r_shadow_dp;

    logic                    w_changed;
    logic                    w_blank;
    logic                    w_one_low;
    logic                    w_hit;
    logic                    w_capture;
    logic                    w_frame;
    logic [IDX_W-1:0]        w_digit_idx;
    logic [NUM_SEGMENTS-1:0] w_seen_next;
    digit_t                  w_nibble;
    logic                    w_legal;

    // Bring the display lines into the clk domain and keep last cycle's copy
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!CPU_RESETN) begin
            r_anode_s1   <= '1;
            r_anode_s2   <= '1;
            r_anode_prev <= '1;
            r_cath_s1    <= '1;
            r_cath_s2    <= '1;
            r_cath_prev  <= '1;
        end else begin
            r_anode_s1   <= anode;
            r_anode_s2   <= r_anode_s1;
            r_anode_prev <= r_anode_s2;
            r_cath_s1    <= cathode;
            r_cath_s2    <= r_cath_s1;
            r_cath_prev  <= r_cath_s2;
        end
    end

    assign w_changed = (r_anode_s2 != r_anode_prev) || (r_cath_s2 != r_cath_prev);
    assign w_blank   = &r_anode_s2;
    assign w_one_low = $onehot(~r_anode_s2);
    assign w_hit     = !w_changed && !w_blank && (r_stable_cnt == CNT_HIT);
    assign w_capture = w_hit && w_one_low && w_legal;
    assign w_frame   = &r_seen;

    // Which digit slot the single low anode selects
    always_comb begin
        w_digit_idx = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (!r_anode_s2[i]) w_digit_idx = IDX_W'(i);
        end
    end

    // Seen mask: cleared when a frame is published, then the new capture ORed in
    always_comb begin
        w_seen_next = w_frame ? '0 : r_seen;
        if (w_capture) w_seen_next = w_seen_next | ~r_anode_s2;
    end

    seg_decode u_seg_decode (
        .i_pattern (~r_cath_s2[SEG_G:SEG_A]),
        .o_nibble  (w_nibble),
        .o_legal   (w_legal)
    );

    // Dwell counter: restarts on any input change or while blanked, saturates at the top
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_stable_cnt <= '0;
        end else if (w_changed || w_blank) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != CNT_MAX) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // Shadow store: latch the decoded digit and raw DP into the selected slot
    always_ff @(posedge clk) begin
        // NOTE: shadow slots carry no reset; the seen mask decides when their contents count.
        if (w_capture) begin
            r_shadow_enc[w_digit_idx] <= w_nibble;
            r_shadow_dp[w_digit_idx]  <= r_cath_s2[SEG_DP];
        end
    end

    // Frame publication and error flags
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_seen      <= '0;
            encoded     <= '0;
            decimal     <= '1;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            r_seen      <= w_seen_next;
            frame_valid <= w_frame;
            glyph_err   <= w_hit && w_one_low && !w_legal;
            if (w_frame) begin
                encoded <= r_shadow_enc;
                decimal <= r_shadow_dp;
            end
            if (w_hit && !w_one_low) multi_err <= 1'b1;
        end
    end

    // Watchdog on frame arrivals: stale once a full timeout passes with no frame
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_to_cnt <= '0;
            stale    <= 1'b0;
        end else if (w_frame) begin
            r_to_cnt <= '0;
            stale    <= 1'b0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_MAX - 1'b1) stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: a display-driver model feeds digits,
// expected frames go into a queue and a monitor checks each frame_valid.
module tb_seven_segment_capture;

    localparam int N       = 8;
    localparam int STABLE  = 16;
    localparam int CLK_PER = 10;
    localparam int REFR    = 1_000_000;
    localparam int TIMEOUT = 400;            // 4 * 1e9 / (10 * 1e6)
    localparam int DWELL   = 24;
    localparam int LATENCY = 2 + STABLE + 1;

    typedef struct packed {
        logic [31:0] enc;
        logic [7:0]  dp;
    } exp_frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  anode = '1;
    logic [7:0]    cathode = '1;
    logic [N*4-1:0] encoded;
    logic [N-1:0]  decimal;
    logic          frame_valid, glyph_err, multi_err, stale;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    exp_frame_t exp_q [$];
    exp_frame_t mon_e;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, drive_cyc = 0, frame_cnt = 0, frame_cyc = 0, glyph_cnt = 0;
    int f_ref;

    seven_segment_capture #(
        .NUM_SEGMENTS (N),
        .STABLE_CYC   (STABLE),
        .CLK_PER      (CLK_PER),
        .REFR_RATE    (REFR)
    ) dut (
        .clk         (clk),
        .CPU_RESETN  (rst_n),
        .anode       (anode),
        .cathode     (cathode),
        .encoded     (encoded),
        .decimal     (decimal),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err),
        .multi_err   (multi_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every frame pulse, counts glyph errors
    always @(negedge clk) begin
        if (glyph_err === 1'b1) glyph_cnt++;
        if (frame_valid === 1'b1) begin
            frame_cnt++;
            frame_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: encoded=%h decimal=%h but no frame expected", encoded, decimal);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_encoded", 64'(encoded), 64'(mon_e.enc));
                check("frame_decimal", 64'(decimal), 64'(mon_e.dp));
            end
        end
    end

    task automatic push_exp(input logic [31:0] enc, input logic [7:0] dp);
        exp_frame_t e;
        e.enc = enc;
        e.dp  = dp;
        exp_q.push_back(e);
    endtask

    task automatic show_raw(input logic [7:0] an, input logic [7:0] ca, input int n);
        @(posedge clk); #1;
        anode     = an;
        cathode   = ca;
        drive_cyc = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic show(input int idx, input int val, input logic dp_raw, input int n);
        logic [7:0] an;
        an = '1;
        an[idx] = 1'b0;
        show_raw(an, {dp_raw, ~glyph[val]}, n);
    endtask

    task automatic show_frame(input logic [31:0] vals, input logic [7:0] dps);
        for (int i = 0; i < N; i++) show(i, int'(vals[i*4 +: 4]), dps[i], DWELL);
    endtask

    task automatic wait_frame(input int target, input int budget, input string name);
        int k = 0;
        while (frame_cnt < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 64'(frame_cnt), 64'(target));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_encoded"}, 64'(encoded), 64'h0);
        check({tag, "_decimal"}, 64'(decimal), 64'hFF);
        check({tag, "_frame_valid"}, 64'(frame_valid), 64'h0);
        check({tag, "_glyph_err"}, 64'(glyph_err), 64'h0);
        check({tag, "_multi_err"}, 64'(multi_err), 64'h0);
        check({tag, "_stale"}, 64'(stale), 64'h0);
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Loopback of 12345678 with DP off, plus end-to-end latency
        push_exp(32'h12345678, 8'hFF);
        show_frame(32'h12345678, 8'hFF);
        wait_frame(1, 20, "t1_frame_count");
        check("t1_latency", 64'(frame_cyc - drive_cyc), 64'(LATENCY));
        check("t1_stale", 64'(stale), 64'h0);

        // Glitchy digit 3 settles on a 6; DP lit on digit 0
        push_exp(32'h76546210, 8'hFE);
        show(0, 0, 1'b0, DWELL);
        show(1, 1, 1'b1, DWELL);
        show(2, 2, 1'b1, DWELL);
        for (int k = 0; k < 20; k++) show(3, (k % 2 == 1) ? 8 : 6, 1'b1, 5);
        show(3, 6, 1'b1, DWELL);
        for (int i = 4; i < N; i++) show(i, i, 1'b1, DWELL);
        wait_frame(2, 20, "t2_frame_count");
        check("t2_no_glyph_err", 64'(glyph_cnt), 64'h0);

        // Illegal pattern 0x55 on digit 0 blocks the frame until a legal digit 0
        show_raw(8'hFE, {1'b1, ~7'h55}, DWELL);
        check("t3_glyph_err_pulse", 64'(glyph_cnt), 64'h1);
        v = 32'hFEDCBA9A;
        for (int i = 1; i < N; i++) show(i, int'(v[i*4 +: 4]), 1'b1, DWELL);
        check("t3_no_frame_yet", 64'(frame_cnt), 64'h2);
        push_exp(32'hFEDCBA9A, 8'hFF);
        show(0, 4'hA, 1'b1, DWELL);
        wait_frame(3, 20, "t3_frame_count");
        check("t3_glyph_err_total", 64'(glyph_cnt), 64'h1);

        // Two anodes low: sticky multi_err, nothing captured
        v = 32'h87654321;
        for (int i = 2; i < N; i++) show(i, int'(v[i*4 +: 4]), (i == 7) ? 1'b0 : 1'b1, DWELL);
        check("t4_multi_err_before", 64'(multi_err), 64'h0);
        show_raw(8'hFC, {1'b1, ~glyph[5]}, 32);
        check("t4_multi_err_set", 64'(multi_err), 64'h1);
        check("t4_no_frame", 64'(frame_cnt), 64'h3);
        push_exp(32'h87654321, 8'h7F);
        show(0, 1, 1'b1, DWELL);
        show(1, 2, 1'b1, DWELL);
        wait_frame(4, 20, "t4_frame_count");
        f_ref = frame_cyc;

        // Blanked display: stale exactly TIMEOUT cycles after the last frame
        @(posedge clk); #1;
        anode   = '1;
        cathode = '1;
        while (cyc < f_ref + TIMEOUT - 1) @(negedge clk);
        #1;
        check("t5_stale_before_timeout", 64'(stale), 64'h0);
        @(negedge clk); #1;
        check("t5_stale_at_timeout", 64'(stale), 64'h1);
        push_exp(32'h12345678, 8'hFF);
        show_frame(32'h12345678, 8'hFF);
        wait_frame(5, 20, "t5_frame_count");
        check("t5_stale_cleared", 64'(stale), 64'h0);

        // Reset mid-frame after 5 digits: partial frame discarded
        v = 32'h89ABCDEF;
        for (int i = 0; i < 5; i++) show(i, int'(v[i*4 +: 4]), 1'b1, DWELL);
        check("t6_multi_err_sticky", 64'(multi_err), 64'h1);
        @(negedge clk); #2;
        rst_n   = 1'b0;
        anode   = '1;
        cathode = '1;
        #2;
        check_reset_values("t6_in_reset");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 5; i < N; i++) show(i, int'(v[i*4 +: 4]), 1'b1, DWELL);
        check("t6_no_partial_frame", 64'(frame_cnt), 64'h5);
        push_exp(32'h89ABCDEF, 8'hFF);
        for (int i = 0; i < 5; i++) show(i, int'(v[i*4 +: 4]), 1'b1, DWELL);
        wait_frame(6, 20, "t6_frame_count");

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
